// File: rtl/fb_pixel_serializer_if.sv
// Framebuffer word stream in, pixel stream out, bundled for the serializer.
// slave = serializer side, master = rasterizer/display side.
interface fb_pixel_serializer_if #(
    parameter int CMD_STREAM_WIDTH = 64,
    parameter int PIXEL_WIDTH      = 16
);
    logic                        s_fb_axis_tvalid;
    logic                        s_fb_axis_tready;
    logic                        s_fb_axis_tlast;
    logic [CMD_STREAM_WIDTH-1:0] s_fb_axis_tdata;

    logic                        m_pix_axis_tvalid;
    logic                        m_pix_axis_tready;
    logic [PIXEL_WIDTH-1:0]      m_pix_axis_tdata;
    logic                        m_pix_axis_tuser;
    logic                        m_pix_axis_tlast;

    modport slave (
        input  s_fb_axis_tvalid,
        output s_fb_axis_tready,
        input  s_fb_axis_tlast,
        input  s_fb_axis_tdata,
        output m_pix_axis_tvalid,
        input  m_pix_axis_tready,
        output m_pix_axis_tdata,
        output m_pix_axis_tuser,
        output m_pix_axis_tlast
    );

    modport master (
        output s_fb_axis_tvalid,
        input  s_fb_axis_tready,
        output s_fb_axis_tlast,
        output s_fb_axis_tdata,
        input  m_pix_axis_tvalid,
        output m_pix_axis_tready,
        input  m_pix_axis_tdata,
        input  m_pix_axis_tuser,
        input  m_pix_axis_tlast
    );
endinterface

// File: rtl/fb_pixel_serializer.sv
// Splits packed framebuffer words into a raster-timed pixel stream.
// Define FB_PIXEL_SERIALIZER_BYTE_SWAP_EN to swap pixel bytes for SPI/8080 panels.
module fb_pixel_serializer #(
    parameter int CMD_STREAM_WIDTH = 64,
    parameter int PIXEL_WIDTH      = 16,
    parameter int X_RESOLUTION     = 128,
    parameter int Y_RESOLUTION     = 128
) (
    input  logic                       aclk,
    input  logic                       resetn,
    fb_pixel_serializer_if.slave       bus,
    output logic                       frame_done
);

    localparam int LANES = CMD_STREAM_WIDTH / PIXEL_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int XW    = $clog2(X_RESOLUTION);
    localparam int YW    = (Y_RESOLUTION > 1) ? $clog2(Y_RESOLUTION) : 1;

    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);
    localparam logic [XW-1:0] X_MAX    = XW'(X_RESOLUTION - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(Y_RESOLUTION - 1);

    if (CMD_STREAM_WIDTH % PIXEL_WIDTH != 0) begin : g_bad_width
        $error("CMD_STREAM_WIDTH must be a multiple of PIXEL_WIDTH");
    end
    if (X_RESOLUTION < 2 || Y_RESOLUTION < 1) begin : g_bad_res
        $error("X_RESOLUTION >= 2 and Y_RESOLUTION >= 1 required");
    end

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    state_t                      state_q, state_d;
    logic [CMD_STREAM_WIDTH-1:0] word_q, word_d;
    logic                        wlast_q, wlast_d;
    logic [LW-1:0]               lane_q, lane_d;
    logic [XW-1:0]               x_q, x_d;
    logic [YW-1:0]               y_q, y_d;
    logic                        frame_done_q, frame_done_d;

    logic                        fb_hs;
    logic                        pix_hs;
    logic                        lane_last;
    logic                        x_last;
    logic                        y_last;
    logic                        last_acc;
    logic                        frame_end;
    logic [PIXEL_WIDTH-1:0]      lane_pix;

    assign lane_last = (lane_q == LANE_MAX);
    assign x_last    = (x_q == X_MAX);
    assign y_last    = (y_q == Y_MAX);

    // Ready is gated by resetn so the upstream never sees ready during reset.
    assign bus.s_fb_axis_tready = resetn &
        ((state_q == EMPTY) | (lane_last & bus.m_pix_axis_tready));

    assign fb_hs    = bus.s_fb_axis_tvalid & bus.s_fb_axis_tready;
    assign pix_hs   = bus.m_pix_axis_tvalid & bus.m_pix_axis_tready;
    assign last_acc = pix_hs & lane_last;

    // Word tlast and raster end can coincide; both fold into one pulse.
    assign frame_end = (last_acc & wlast_q) | (pix_hs & x_last & y_last);

    always_comb begin
        lane_pix = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                lane_pix = word_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

`ifdef FB_PIXEL_SERIALIZER_BYTE_SWAP_EN
    assign bus.m_pix_axis_tdata = {lane_pix[PIXEL_WIDTH/2-1:0],
                                   lane_pix[PIXEL_WIDTH-1:PIXEL_WIDTH/2]};
`else
    assign bus.m_pix_axis_tdata = lane_pix;
`endif

    assign bus.m_pix_axis_tvalid = (state_q == HOLD);
    assign bus.m_pix_axis_tuser  = (x_q == '0) & (y_q == '0);
    assign bus.m_pix_axis_tlast  = x_last;
    assign frame_done            = frame_done_q;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        wlast_d      = wlast_q;
        lane_d       = lane_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (fb_hs) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (last_acc && !fb_hs) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (fb_hs) begin
            word_d  = bus.s_fb_axis_tdata;
            wlast_d = bus.s_fb_axis_tlast;
        end

        if (pix_hs) begin
            lane_d = lane_last ? '0 : lane_q + 1'b1;
            if (frame_end) begin
                x_d          = '0;
                y_d          = '0;
                frame_done_d = 1'b1;
            end else if (x_last) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= EMPTY;
            word_q       <= '0;
            wlast_q      <= 1'b0;
            lane_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            wlast_q      <= wlast_d;
            lane_q       <= lane_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_serializer.sv
// Directed bench for fb_pixel_serializer with an 8x2 raster and 4 lanes.
// Expected pixel data follows FB_PIXEL_SERIALIZER_BYTE_SWAP_EN when defined.
module tb_fb_pixel_serializer;

    localparam int CW = 64;
    localparam int PW = 16;
    localparam int XR = 8;
    localparam int YR = 2;

    logic aclk = 1'b0;
    logic resetn = 1'b0;
    logic frame_done;

    int n_chk = 0;
    int n_pass = 0;

    fb_pixel_serializer_if #(.CMD_STREAM_WIDTH(CW), .PIXEL_WIDTH(PW)) bus ();

    fb_pixel_serializer #(
        .CMD_STREAM_WIDTH(CW),
        .PIXEL_WIDTH     (PW),
        .X_RESOLUTION    (XR),
        .Y_RESOLUTION    (YR)
    ) dut (
        .aclk      (aclk),
        .resetn    (resetn),
        .bus       (bus),
        .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    function automatic logic [15:0] sw(input logic [15:0] p);
`ifdef FB_PIXEL_SERIALIZER_BYTE_SWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    function automatic logic [15:0] pix(input int k);
        return 16'h0A01 + 16'(k) * 16'h0102;
    endfunction

    function automatic logic [63:0] wrd(input int j);
        return {pix(4*j+3), pix(4*j+2), pix(4*j+1), pix(4*j)};
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        bus.s_fb_axis_tvalid = 1'b0;
        bus.s_fb_axis_tlast = 1'b0;
        bus.s_fb_axis_tdata = '0;
        bus.m_pix_axis_tready = 1'b1;
        repeat (2) @(negedge aclk);
        resetn = 1'b1;
    endtask

    task automatic drain();
        bus.s_fb_axis_tvalid = 1'b0;
        bus.m_pix_axis_tready = 1'b1;
        repeat (5) @(negedge aclk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.s_fb_axis_tvalid = 1'b1;
        bus.m_pix_axis_tready = 1'b1;
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.s_fb_axis_tready, frame_done} !== 3'b000)
            $display("FAIL reset_outs: got %b want 000",
                     {bus.m_pix_axis_tvalid, bus.s_fb_axis_tready, frame_done});
        else n_pass++;
        @(negedge aclk);
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.s_fb_axis_tready} !== 2'b00)
            $display("FAIL reset_hold: got %b want 00",
                     {bus.m_pix_axis_tvalid, bus.s_fb_axis_tready});
        else n_pass++;
        bus.s_fb_axis_tvalid = 1'b0;
        resetn = 1'b1;
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.s_fb_axis_tready} !== 2'b01)
            $display("FAIL reset_release: got %b want 01",
                     {bus.m_pix_axis_tvalid, bus.s_fb_axis_tready});
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [15:0] e [4];
        e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_reset();
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = 64'h4444_3333_2222_1111;
        #1;
        n_chk++;
        if (bus.s_fb_axis_tready !== 1'b1)
            $display("FAIL stream_ready: got %b want 1", bus.s_fb_axis_tready);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            bus.s_fb_axis_tvalid = 1'b0;
            #1;
            n_chk++;
            if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                 bus.m_pix_axis_tuser, bus.m_pix_axis_tlast}
                !== {1'b1, sw(e[i]), (i == 0), 1'b0})
                $display("FAIL stream_pix%0d: got v%b d%h u%b l%b want d%h u%b",
                         i, bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                         bus.m_pix_axis_tuser, bus.m_pix_axis_tlast,
                         sw(e[i]), (i == 0));
            else n_pass++;
        end
        @(negedge aclk);
        #1;
        n_chk++;
        if (bus.m_pix_axis_tvalid !== 1'b0)
            $display("FAIL stream_idle: got %b want 0", bus.m_pix_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e [8];
        e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
              16'h5555, 16'h6666, 16'h7777, 16'h8888};
        do_reset();
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = 64'h4444_3333_2222_1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (i == 0) bus.s_fb_axis_tdata = 64'h8888_7777_6666_5555;
            if (i == 4) bus.s_fb_axis_tvalid = 1'b0;
            #1;
            n_chk++;
            if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                 bus.m_pix_axis_tuser, bus.m_pix_axis_tlast}
                !== {1'b1, sw(e[i]), (i == 0), (i == 7)})
                $display("FAIL b2b_pix%0d: got v%b d%h u%b l%b want d%h",
                         i, bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                         bus.m_pix_axis_tuser, bus.m_pix_axis_tlast, sw(e[i]));
            else n_pass++;
            n_chk++;
            if (bus.s_fb_axis_tready !== (i % 4 == 3))
                $display("FAIL b2b_ready%0d: got %b want %b",
                         i, bus.s_fb_axis_tready, (i % 4 == 3));
            else n_pass++;
        end
        @(negedge aclk);
        #1;
        n_chk++;
        if (bus.m_pix_axis_tvalid !== 1'b0)
            $display("FAIL b2b_idle: got %b want 0", bus.m_pix_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [15:0] e [4];
        e = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        do_reset();
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = 64'hDDDD_CCCC_BBBB_AAAA;
        for (int c = 0; c < 7; c++) begin
            @(negedge aclk);
            bus.s_fb_axis_tvalid = 1'b0;
            bus.m_pix_axis_tready = (c % 2 == 0);
            #1;
            n_chk++;
            if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata}
                !== {1'b1, sw(e[(c+1)/2])})
                $display("FAIL bp_pix_c%0d: got v%b d%h want d%h", c,
                         bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                         sw(e[(c+1)/2]));
            else n_pass++;
            n_chk++;
            if (bus.s_fb_axis_tready !== (c == 6))
                $display("FAIL bp_ready_c%0d: got %b want %b",
                         c, bus.s_fb_axis_tready, (c == 6));
            else n_pass++;
        end
        @(negedge aclk);
        bus.m_pix_axis_tready = 1'b1;
        #1;
        n_chk++;
        if (bus.m_pix_axis_tvalid !== 1'b0)
            $display("FAIL bp_idle: got %b want 0", bus.m_pix_axis_tvalid);
        else n_pass++;
    endtask

    task automatic test_frame();
        do_reset();
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = wrd(0);
        bus.s_fb_axis_tlast = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge aclk);
            if (i % 4 == 0) begin
                if (i < 12) begin
                    bus.s_fb_axis_tdata = wrd(i/4 + 1);
                    bus.s_fb_axis_tlast = (i == 8);
                end else begin
                    bus.s_fb_axis_tvalid = 1'b0;
                    bus.s_fb_axis_tlast = 1'b0;
                end
            end
            #1;
            n_chk++;
            if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                 bus.m_pix_axis_tuser, bus.m_pix_axis_tlast}
                !== {1'b1, sw(pix(i)), (i == 0), (i == 7 || i == 15)})
                $display("FAIL frame_pix%0d: got v%b d%h u%b l%b want d%h u%b l%b",
                         i, bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                         bus.m_pix_axis_tuser, bus.m_pix_axis_tlast,
                         sw(pix(i)), (i == 0), (i == 7 || i == 15));
            else n_pass++;
            n_chk++;
            if (frame_done !== 1'b0)
                $display("FAIL frame_done_early%0d: got %b want 0", i, frame_done);
            else n_pass++;
        end
        @(negedge aclk);
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = wrd(0);
        #1;
        n_chk++;
        if ({frame_done, bus.m_pix_axis_tvalid} !== 2'b10)
            $display("FAIL frame_done_pulse: got %b want 10",
                     {frame_done, bus.m_pix_axis_tvalid});
        else n_pass++;
        @(negedge aclk);
        bus.s_fb_axis_tvalid = 1'b0;
        #1;
        n_chk++;
        if (frame_done !== 1'b0)
            $display("FAIL frame_done_single: got %b want 0", frame_done);
        else n_pass++;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata, bus.m_pix_axis_tuser}
            !== {1'b1, sw(pix(0)), 1'b1})
            $display("FAIL frame_next_tuser: got v%b d%h u%b want d%h u1",
                     bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                     bus.m_pix_axis_tuser, sw(pix(0)));
        else n_pass++;
        drain();
    endtask

    task automatic test_early_tlast();
        do_reset();
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = wrd(0);
        bus.s_fb_axis_tlast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            bus.s_fb_axis_tvalid = 1'b0;
            bus.s_fb_axis_tlast = 1'b0;
            #1;
            n_chk++;
            if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                 bus.m_pix_axis_tuser, bus.m_pix_axis_tlast, frame_done}
                !== {1'b1, sw(pix(i)), (i == 0), 1'b0, 1'b0})
                $display("FAIL early_pix%0d: got v%b d%h u%b l%b fd%b want d%h",
                         i, bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                         bus.m_pix_axis_tuser, bus.m_pix_axis_tlast,
                         frame_done, sw(pix(i)));
            else n_pass++;
        end
        @(negedge aclk);
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = wrd(1);
        #1;
        n_chk++;
        if ({frame_done, bus.m_pix_axis_tvalid} !== 2'b10)
            $display("FAIL early_done: got %b want 10",
                     {frame_done, bus.m_pix_axis_tvalid});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            bus.s_fb_axis_tvalid = 1'b0;
            #1;
            n_chk++;
            if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                 bus.m_pix_axis_tuser, bus.m_pix_axis_tlast, frame_done}
                !== {1'b1, sw(pix(4+i)), (i == 0), 1'b0, 1'b0})
                $display("FAIL early_next%0d: got v%b d%h u%b l%b fd%b want d%h u%b",
                         i, bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                         bus.m_pix_axis_tuser, bus.m_pix_axis_tlast,
                         frame_done, sw(pix(4+i)), (i == 0));
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = 64'h0D0D_0C0C_0B0B_0A0A;
        @(negedge aclk);
        bus.s_fb_axis_tvalid = 1'b0;
        @(negedge aclk);
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata}
            !== {1'b1, sw(16'h0B0B)})
            $display("FAIL mid_pix1: got v%b d%h want d%h",
                     bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata, sw(16'h0B0B));
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.s_fb_axis_tready, frame_done} !== 3'b000)
            $display("FAIL mid_reset: got %b want 000",
                     {bus.m_pix_axis_tvalid, bus.s_fb_axis_tready, frame_done});
        else n_pass++;
        repeat (2) @(negedge aclk);
        resetn = 1'b1;
        bus.s_fb_axis_tvalid = 1'b1;
        bus.s_fb_axis_tdata = 64'h9ABC_DEF0_5678_1234;
        #1;
        n_chk++;
        if (bus.s_fb_axis_tready !== 1'b1)
            $display("FAIL mid_ready: got %b want 1", bus.s_fb_axis_tready);
        else n_pass++;
        @(negedge aclk);
        bus.s_fb_axis_tvalid = 1'b0;
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata, bus.m_pix_axis_tuser}
            !== {1'b1, sw(16'h1234), 1'b1})
            $display("FAIL mid_lane0: got v%b d%h u%b want d%h u1",
                     bus.m_pix_axis_tvalid, bus.m_pix_axis_tdata,
                     bus.m_pix_axis_tuser, sw(16'h1234));
        else n_pass++;
        @(negedge aclk);
        #1;
        n_chk++;
        if ({bus.m_pix_axis_tdata, bus.m_pix_axis_tuser} !== {sw(16'h5678), 1'b0})
            $display("FAIL mid_lane1: got d%h u%b want d%h u0",
                     bus.m_pix_axis_tdata, bus.m_pix_axis_tuser, sw(16'h5678));
        else n_pass++;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.s_fb_axis_tvalid = 1'b0;
        bus.s_fb_axis_tlast = 1'b0;
        bus.s_fb_axis_tdata = '0;
        bus.m_pix_axis_tready = 1'b1;
        @(negedge aclk);
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_frame();
        test_early_tlast();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
